// File: rtl/wb_trace_buffer.sv
// Write-back trace buffer: captures committed (rd, data, seq) triples into a
// first-word-fall-through FIFO drained over a valid/ready stream; drops are counted.
module wb_trace_buffer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned SEQ_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_valid,
    input  logic [4:0]               wb_reg_addr,
    input  logic [31:0]              wb_data,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [4:0]               out_reg_addr,
    output logic [31:0]              out_data,
    output logic [SEQ_W-1:0]         out_seq,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic [15:0]              overflow_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DepthC = CNT_W'(DEPTH);

    logic [4:0]       mem_addr [DEPTH];
    logic [31:0]      mem_data [DEPTH];
    logic [SEQ_W-1:0] mem_seq  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [SEQ_W-1:0] seq_q;
    logic [15:0]      ovf_q;

    logic commit, pop, push, drop;

    always_comb begin
        out_valid = (count_q != '0);
        full      = (count_q == DepthC);
        commit    = wb_valid && (wb_reg_addr != 5'd0);
        pop       = out_valid && out_ready;
        // A full FIFO can still accept when the head leaves in the same cycle.
        push      = commit && (!full || pop);
        drop      = commit && !push;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            seq_q    <= '0;
            ovf_q    <= '0;
        end else begin
            // seq advances on every commit, even dropped or cleared ones.
            if (commit) begin
                seq_q <= seq_q + SEQ_W'(1);
            end
            if (clear) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                ovf_q    <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                if (push && !pop) begin
                    count_q <= count_q + CNT_W'(1);
                end else if (pop && !push) begin
                    count_q <= count_q - CNT_W'(1);
                end
                if (drop && (ovf_q != 16'hFFFF)) begin
                    ovf_q <= ovf_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_addr[i] <= '0;
                mem_data[i] <= '0;
                mem_seq[i]  <= '0;
            end
        end else if (push && !clear) begin
            mem_addr[wr_ptr_q] <= wb_reg_addr;
            mem_data[wr_ptr_q] <= wb_data;
            mem_seq[wr_ptr_q]  <= seq_q;
        end
    end

    assign out_reg_addr = mem_addr[rd_ptr_q];
    assign out_data     = mem_data[rd_ptr_q];
    assign out_seq      = mem_seq[rd_ptr_q];
    assign count        = count_q;
    assign overflow_cnt = ovf_q;

endmodule
